job_dispatcher: RTL and testbench

Sits directly downstream of the job manager. It consumes `job_start` and the 512-bit `system_register` descriptor, and selects a free kernel among `KERNEL_NUM` by round-robin. It issues the descriptor to that kernel with a one-cycle start pulse and tracks per-kernel busy state. It also produces the `new_job` / `job_done` feedback the job manager waits on.

---
 rtl/job_dispatcher_pkg.sv | 19 +
 rtl/job_dispatcher_rr_free_select.sv | 30 +++
 rtl/job_dispatcher.sv | 129 ++++++++++++
 tb/tb_job_dispatcher.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/job_dispatcher_pkg.sv
// Shared types and widths for the job dispatcher and its kernel-pool helpers.
package job_dispatcher_pkg;

    localparam int DESC_W   = 512;
    localparam int ISSUED_W = 32;
    localparam int CNT_W    = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_REG = 2'd1,
        ISSUE    = 2'd2
    } state_e;

    // Index width that stays legal for a single-kernel pool.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/job_dispatcher_rr_free_select.sv
// Round-robin picker: first set bit of free at or after ptr, wrapping at N-1.
module rr_free_select
    import job_dispatcher_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     free,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] sel_idx,
    output logic             any_free
);

    logic [IDX_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest free kernel wins.
    always_comb begin
        sel_idx  = '0;
        any_free = 1'b0;
        cand     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr) + k) % N);
            if (free[cand]) begin
                sel_idx  = cand;
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/job_dispatcher.sv
// Accepts jobs from the job manager, waits for the descriptor, and issues it to
// a free kernel chosen round-robin while tracking per-kernel busy state.
module job_dispatcher
    import job_dispatcher_pkg::*;
#(
    parameter int KERNEL_NUM  = 8,
    parameter int REG_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  job_start,
    input  logic [DESC_W-1:0]     system_register,
    input  logic [KERNEL_NUM-1:0] kernel_done,
    output logic                  new_job,
    output logic                  job_done,
    output logic [KERNEL_NUM-1:0] kernel_start,
    output logic [DESC_W-1:0]     kernel_job,
    output logic [KERNEL_NUM-1:0] kernel_busy,
    output logic [ISSUED_W-1:0]   jobs_issued,
    output logic                  err_spurious_done
);

    localparam int IDX_W = idx_w(KERNEL_NUM);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(REG_LATENCY - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KERNEL_NUM - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      sel_q, sel_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [DESC_W-1:0]     job_q, job_d;
    logic [KERNEL_NUM-1:0] start_q, start_d;
    logic [KERNEL_NUM-1:0] busy_q, busy_d;
    logic [ISSUED_W-1:0]   issued_q, issued_d;
    logic                  err_q, err_d;

    logic [KERNEL_NUM-1:0] free_vec;
    logic [KERNEL_NUM-1:0] set_vec;
    logic [IDX_W-1:0]      pick_idx;
    logic                  any_free;

    assign free_vec = ~busy_q;

    rr_free_select #(
        .N     (KERNEL_NUM),
        .IDX_W (IDX_W)
    ) u_rr_free_select (
        .free     (free_vec),
        .ptr      (rr_ptr_q),
        .sel_idx  (pick_idx),
        .any_free (any_free)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        job_d    = job_q;
        start_d  = '0;
        issued_d = issued_q;
        set_vec  = '0;
        unique case (state_q)
            IDLE: begin
                // A start with every kernel busy is dropped without trace.
                if (job_start && any_free) begin
                    state_d = WAIT_REG;
                    cnt_d   = CNT_INIT;
                    sel_d   = pick_idx;
                end
            end
            WAIT_REG: begin
                if (cnt_q == '0) begin
                    state_d = ISSUE;
                    job_d   = system_register;
                    for (int i = 0; i < KERNEL_NUM; i++) begin
                        set_vec[i] = (sel_q == IDX_W'(i));
                    end
                    start_d  = set_vec;
                    issued_d = issued_q + ISSUED_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ISSUE: begin
                state_d  = IDLE;
                rr_ptr_d = (sel_q == LAST_IDX) ? '0 : sel_q + IDX_W'(1);
            end
            default: state_d = IDLE;
        endcase

        // Set wins over a same-cycle done; that done is spurious and flagged below.
        busy_d = (busy_q & ~kernel_done) | set_vec;
        err_d  = err_q | (|(kernel_done & ~busy_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sel_q    <= '0;
            rr_ptr_q <= '0;
            job_q    <= '0;
            start_q  <= '0;
            busy_q   <= '0;
            issued_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
            job_q    <= job_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            issued_q <= issued_d;
            err_q    <= err_d;
        end
    end

    assign new_job           = (state_q == IDLE) && any_free;
    assign job_done          = (state_q == IDLE) && (busy_q == '0);
    assign kernel_start      = start_q;
    assign kernel_job        = job_q;
    assign kernel_busy       = busy_q;
    assign jobs_issued       = issued_q;
    assign err_spurious_done = err_q;

endmodule

// File: tb/tb_job_dispatcher.sv
// Bench for job_dispatcher: directed vector table, round-robin/reset sequences,
// and random traffic checked against a timeline model of the dispatcher.
module tb_job_dispatcher;

    localparam int N = 8;
    localparam int L = 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         job_start = 1'b0;
    logic [511:0] system_register = '0;
    logic [N-1:0] kernel_done = '0;
    logic         new_job, job_done, err_spurious_done;
    logic [N-1:0] kernel_start, kernel_busy;
    logic [511:0] kernel_job;
    logic [31:0]  jobs_issued;

    int n_chk  = 0;
    int n_fail = 0;

    job_dispatcher #(.KERNEL_NUM(N), .REG_LATENCY(L)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .job_start         (job_start),
        .system_register   (system_register),
        .kernel_done       (kernel_done),
        .new_job           (new_job),
        .job_done          (job_done),
        .kernel_start      (kernel_start),
        .kernel_job        (kernel_job),
        .kernel_busy       (kernel_busy),
        .jobs_issued       (jobs_issued),
        .err_spurious_done (err_spurious_done)
    );

    always #5 clk = ~clk;

    // Reference model: busy flags per kernel, a pending-issue countdown and an
    // "issuing" marker; idle means nothing pending and not in the issue cycle.
    bit           mb[N];
    int           m_rr, m_pend, m_sel;
    bit           m_issuing, m_err;
    logic [511:0] m_job;
    logic [N-1:0] m_start;
    int unsigned  m_issued;

    function automatic int first_free();
        for (int k = 0; k < N; k++) begin
            if (!mb[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    function automatic bit m_idle();
        return (m_pend < 0) && !m_issuing;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) mb[i] = 1'b0;
        m_rr = 0; m_pend = -1; m_sel = 0; m_issuing = 1'b0; m_err = 1'b0;
        m_job = '0; m_start = '0; m_issued = 0;
    endtask

    task automatic model_edge(input bit js, input logic [N-1:0] kd, input logic [511:0] sys);
        bit pre_idle;
        int ff;
        bit nb[N];
        pre_idle = m_idle();
        ff = first_free();
        m_start = '0;
        for (int i = 0; i < N; i++) begin
            nb[i] = mb[i];
            if (kd[i]) begin
                if (mb[i]) nb[i] = 1'b0;
                else m_err = 1'b1;
            end
        end
        if (m_issuing) begin
            m_rr = (m_sel + 1) % N;
            m_issuing = 1'b0;
        end
        if (m_pend > 0) begin
            m_pend--;
            if (m_pend == 0) begin
                m_job = sys;
                m_start[m_sel] = 1'b1;
                nb[m_sel] = 1'b1;
                m_issued++;
                m_issuing = 1'b1;
                m_pend = -1;
            end
        end
        if (pre_idle && js && ff >= 0) begin
            m_sel = ff;
            m_pend = L;
        end
        for (int i = 0; i < N; i++) mb[i] = nb[i];
    endtask

    function automatic logic [N-1:0] m_busy_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = mb[i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model();
        logic [N-1:0] eb;
        eb = m_busy_vec();
        chk("m_kernel_start", kernel_start, m_start);
        chk("m_kernel_busy", kernel_busy, eb);
        chk("m_new_job", new_job, m_idle() && (eb != '1));
        chk("m_job_done", job_done, m_idle() && (eb == '0));
        chk("m_jobs_issued", jobs_issued, m_issued);
        chk("m_err", err_spurious_done, m_err);
        chk("m_kernel_job", kernel_job, m_job);
    endtask

    task automatic step(input bit js, input logic [N-1:0] kd, input logic [511:0] sys);
        job_start = js;
        kernel_done = kd;
        system_register = sys;
        @(posedge clk);
        model_edge(js, kd, sys);
        #1;
        check_model();
        job_start = 1'b0;
        kernel_done = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        job_start = 1'b0;
        kernel_done = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One full job: start, wait L cycles, check the issue cycle, return to IDLE.
    task automatic run_job(input logic [N-1:0] exp_start, input logic [511:0] sys);
        step(1'b1, '0, sys);
        repeat (L) step(1'b0, '0, sys);
        chk("rr_start", kernel_start, exp_start);
        step(1'b0, '0, sys);
    endtask

    typedef struct {
        bit           js;
        logic [N-1:0] kd;
        logic [7:0]   sys;
        logic [N-1:0] e_start;
        logic [N-1:0] e_busy;
        bit           e_nj;
        bit           e_jd;
        int unsigned  e_iss;
        bit           e_err;
        logic [7:0]   e_job;
    } vec_t;

    vec_t         tbl[12];
    logic [511:0] sysv, ejob;

    initial begin
        tbl[0]  = '{1'b0, 8'h00, 8'hA5, 8'h00, 8'h00, 1'b1, 1'b1, 0, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 8'h00, 8'hA5, 8'h00, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 8'h00, 8'hA5, 8'h01, 8'h01, 1'b0, 1'b0, 1, 1'b0, 8'hA5};
        tbl[3]  = '{1'b0, 8'h00, 8'hA5, 8'h00, 8'h01, 1'b1, 1'b0, 1, 1'b0, 8'hA5};
        tbl[4]  = '{1'b0, 8'h01, 8'hA5, 8'h00, 8'h00, 1'b1, 1'b1, 1, 1'b0, 8'hA5};
        tbl[5]  = '{1'b0, 8'h10, 8'hA5, 8'h00, 8'h00, 1'b1, 1'b1, 1, 1'b1, 8'hA5};
        tbl[6]  = '{1'b1, 8'h00, 8'hA5, 8'h00, 8'h00, 1'b0, 1'b0, 1, 1'b1, 8'hA5};
        tbl[7]  = '{1'b0, 8'h00, 8'h5A, 8'h02, 8'h02, 1'b0, 1'b0, 2, 1'b1, 8'h5A};
        tbl[8]  = '{1'b1, 8'h00, 8'h5A, 8'h00, 8'h02, 1'b1, 1'b0, 2, 1'b1, 8'h5A};
        tbl[9]  = '{1'b1, 8'h00, 8'h5A, 8'h00, 8'h02, 1'b0, 1'b0, 2, 1'b1, 8'h5A};
        tbl[10] = '{1'b0, 8'h02, 8'h3C, 8'h04, 8'h04, 1'b0, 1'b0, 3, 1'b1, 8'h3C};
        tbl[11] = '{1'b0, 8'h00, 8'h3C, 8'h00, 8'h04, 1'b1, 1'b0, 3, 1'b1, 8'h3C};

        do_reset();
        chk("reset_new_job", new_job, 1'b1);
        chk("reset_job_done", job_done, 1'b1);
        chk("reset_busy", kernel_busy, '0);
        chk("reset_issued", jobs_issued, '0);

        for (int r = 0; r < 12; r++) begin
            sysv = {64{tbl[r].sys}};
            ejob = {64{tbl[r].e_job}};
            step(tbl[r].js, tbl[r].kd, sysv);
            chk("tbl_start", kernel_start, tbl[r].e_start);
            chk("tbl_busy", kernel_busy, tbl[r].e_busy);
            chk("tbl_new_job", new_job, tbl[r].e_nj);
            chk("tbl_job_done", job_done, tbl[r].e_jd);
            chk("tbl_issued", jobs_issued, tbl[r].e_iss);
            chk("tbl_err", err_spurious_done, tbl[r].e_err);
            chk("tbl_job", kernel_job, ejob);
        end

        // Round-robin fill, rejected ninth start, then reuse of freed kernels.
        do_reset();
        for (int j = 0; j < N; j++) begin
            logic [N-1:0] oh;
            oh = '0;
            oh[j] = 1'b1;
            run_job(oh, {16{32'(j)}});
        end
        chk("full_new_job", new_job, 1'b0);
        run_job('0, '0);
        chk("full_issued", jobs_issued, 32'd8);
        chk("full_busy", kernel_busy, 8'hFF);
        step(1'b0, 8'h08, '0);
        chk("reuse_new_job", new_job, 1'b1);
        run_job(8'h08, '1);
        step(1'b0, 8'h41, '1);
        run_job(8'h40, '1);
        chk("reuse_issued", jobs_issued, 32'd10);

        // Reset asserted while waiting for the descriptor.
        step(1'b0, 8'h01, '1);
        step(1'b1, '0, '1);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_model();
        chk("rst_job_done", job_done, 1'b1);
        @(posedge clk);
        #1;
        chk("rst_no_start", kernel_start, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(1'b0, '0, '0);

        // Random traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            logic [511:0] rs;
            logic [N-1:0] kd;
            for (int w = 0; w < 16; w++) rs[w*32 +: 32] = $urandom();
            kd = m_busy_vec() & N'($urandom()) & N'($urandom());
            if ($urandom_range(0, 49) == 0) kd = N'($urandom());
            step($urandom_range(0, 2) == 0, kd, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
